alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational ALU used in the CS552 datapath.
- Width is configurable. Adds rotates, a carry flag, an illegal-op flag and an iterative multi-cycle unsigned multiply.
- Operands and opcode are accepted on a valid/ready input port. Result and flags are held in output registers until the consumer accepts them.
- Sits between decode/register-read and writeback; multi-cycle ops stall the pipe via in_ready.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), derived width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation
- op  in  4  opcode (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift/rotate amount
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- z  out  1  result == 0
- n  out  1  result[WIDTH-1]
- v  out  1  signed overflow
- c  out  1  carry / no-borrow
- err  out  1  illegal opcode

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; result, z, n, v, c, err, out_valid and internal mul registers = 0; in_ready = 1 once rst_n is high. Reset mid-multiply aborts the operation; nothing is emitted.
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 NAND ~(a&b)
  - 3 XOR a^b
  - 4 INC a+1
  - 5 SRA arithmetic right
  - 6 SRL logical right
  - 7 SLL left
  - 8 ROL rotate left
  - 9 ROR rotate right
  - 10 MUL low WIDTH bits of unsigned a*b
  - 11-15 illegal
- FSM states IDLE, MUL, DONE:
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Ops 0-9 and illegal: compute and register the result at the accept edge; go to DONE. out_valid is high the next cycle (latency 1).
    - MUL: latch a into the multiplicand, b into the multiplier, clear the accumulator, count=0; go to MUL.
  - MUL: shift-add, one multiplier bit per cycle, LSB first: if mplr[0], acc += mcand; mcand <<= 1; mplr >>= 1. After WIDTH iterations, register acc as the result and go to DONE. Accept-to-out_valid latency = WIDTH+1 cycles; in_ready=0 throughout.
  - DONE: out_valid=1; result and flags held stable. On out_ready go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Arithmetic (all modulo 2^WIDTH):
  - SUB computed as a + ~b + 1.
  - ADD: v = (a[W-1]==b[W-1]) & (r[W-1]!=a[W-1]); c = carry out.
  - SUB: v = (a[W-1]!=b[W-1]) & (r[W-1]!=a[W-1]); c = carry out of a+~b+1 (1 = no borrow).
  - INC: v = (a == 0111..1); c = (a == all ones).
  - All other ops: v = 0, c = 0.
- Shift amount: only b[SHW-1:0] is used; upper b bits are ignored. Amount 0 passes a unchanged.
- Illegal op: result = 0, z = 1, n = v = c = 0, err = 1, latency 1. err = 0 for every legal op.
- z and n always derive from the registered result, including MUL.
- Inputs are ignored while in_ready=0. Changing a/b during MUL has no effect.

Decomposition:
- Shared package alu_pkg holds the 4-bit opcode localparams (ALU_ADD..ALU_MUL) and state encodings; decode and bench both import it.
- One natural sub-module: alu_seq_comb. It is purely combinational, parametrised by WIDTH, and computes result/v/c/err for ops 0-9 and illegal.
- The top holds the FSM, the shift-add multiplier and the output registers.

Test Plan (WIDTH=16):
- ADD 0x7FFF+0x0001, out_ready=1 -> 1 cycle later result=0x8000, v=1, n=1, z=0, c=0; SUB 0x0005-0x0005 -> result=0x0000, z=1, c=1, v=0.
- Shifts/rotates, a=0x8001: SRA by b=0x0011 (amount 1) -> 0xC000; SRL by 1 -> 0x4000; ROL by 4 -> 0x0018; ROR by 1 -> 0xC000; SLL by 0 -> 0x8001.
- MUL 0x0123*0x0045 -> out_valid exactly 17 cycles after accept, result=0x4E6F, in_ready=0 for the whole interval. MUL 0xFFFF*0xFFFF -> result=0x0001.
- Backpressure: NAND 0xF0F0,0xFF00 with out_ready=0 for 5 cycles -> result=0x0FFF held stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> in_ready returns one cycle later.
- Illegal op 12 -> result=0, z=1, err=1; next legal XOR 0xAAAA^0x5555 -> 0xFFFF, err=0, n=1.
- Assert rst_n=0 asynchronously mid-MUL (cycle 6) -> all outputs 0 immediately, out_valid never pulses; after release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  // 4-bit opcode encodings; 11..15 are illegal.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_NAND = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_INC  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage : alu_pkg

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: result, overflow, carry and illegal-op flag
// for every opcode except MUL, which the top handles iteratively.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_v,
  output logic             o_c,
  output logic             o_err
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;

  // Only the low SHW bits of b select the shift/rotate distance.
  assign w_sh = i_b[SHW-1:0];

  // One extra bit captures the carry out; SUB is a + ~b + 1 so its carry
  // out reads as "no borrow".
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

  // Rotating a doubled copy and taking one half avoids a separate
  // (WIDTH - amount) shift and handles amount 0 naturally.
  assign w_rol = {i_a, i_a} << w_sh;
  assign w_ror = {i_a, i_a} >> w_sh;

  // Opcode decode and flag generation.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_result = '0;
    o_v      = 1'b0;
    o_c      = 1'b0;
    o_err    = 1'b0;
    unique case (i_op)
      ALU_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        o_c      = w_sum[WIDTH];
      end
      ALU_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (w_diff[WIDTH-1] != i_a[WIDTH-1]);
        o_c      = w_diff[WIDTH];
      end
      ALU_NAND: o_result = ~(i_a & i_b);
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_INC: begin
        o_result = i_a + WIDTH'(1);
        o_v      = (i_a == MAX_POS);
        o_c      = &i_a;
      end
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_sh);
      ALU_SRL:  o_result = i_a >> w_sh;
      ALU_SLL:  o_result = i_a << w_sh;
      ALU_ROL:  o_result = w_rol[2*WIDTH-1:WIDTH];
      ALU_ROR:  o_result = w_ror[WIDTH-1:0];
      ALU_MUL:  o_result = '0;  // produced by the iterative multiplier
      default:  o_err    = 1'b1;
    endcase
  end

endmodule : alu_seq_comb

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops complete at the accept edge,
// MUL runs a WIDTH-cycle shift-add; results are held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             c,
  output logic             err
);

  alu_state_t       r_state;
  alu_state_t       w_state_next;

  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic             r_c;
  logic             r_err;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_v;
  logic             w_alu_c;
  logic             w_alu_err;
  logic             w_accept;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_acc_step;

  alu_seq_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_comb (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_alu_result),
    .o_v      (w_alu_v),
    .o_c      (w_alu_c),
    .o_err    (w_alu_err)
  );

  assign w_accept   = (r_state == ST_IDLE) & in_valid;
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_step = r_mplr[0] ? (r_acc + r_mcand) : r_acc;

  // Held low during reset so nothing upstream sees a spurious ready.
  assign in_ready  = (r_state == ST_IDLE) & rst_n;
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign z         = r_z;
  assign n         = r_n;
  assign v         = r_v;
  assign c         = r_c;
  assign err       = r_err;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, iterate in MUL, hold in DONE until consumed.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)   w_state_next = (op == ALU_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (w_mul_last) w_state_next = ST_DONE;
      ST_DONE: if (out_ready)  w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // Output registers and shift-add multiplier; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_c      <= 1'b0;
      r_err    <= 1'b0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (op == ALU_MUL) begin
        r_mcand <= a;
        r_mplr  <= b;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        r_result <= w_alu_result;
        r_z      <= (w_alu_result == '0);
        r_n      <= w_alu_result[WIDTH-1];
        r_v      <= w_alu_v;
        r_c      <= w_alu_c;
        r_err    <= w_alu_err;
      end
    end else if (r_state == ST_MUL) begin
      r_acc   <= w_acc_step;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + SHW'(1);
      if (w_mul_last) begin
        r_result <= w_acc_step;
        r_z      <= (w_acc_step == '0);
        r_n      <= w_acc_step[WIDTH-1];
        r_v      <= 1'b0;
        r_c      <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

endmodule : alu_seq

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        z, n, v, c, err;

  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  flg;  // {z, n, v, c, err}
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc;
  int   lat;
  bit   rdy_seen;
  bit   vld_seen;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .n         (n),
    .v         (v),
    .c         (c),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic fz, fn, fv, fc, fe);
    exp_t e;
    e.res = r;
    e.flg = {fz, fn, fv, fc, fe};
    return e;
  endfunction

  // Present one operation at a negedge and hold it across the accept edge.
  task automatic issue(input logic [3:0] f_op, input logic [15:0] f_a, input logic [15:0] f_b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = f_op;
    a  = f_a;
    b  = f_b;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard head, consume.
  task automatic collect(input string tag);
    exp_t e;
    int   k = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    lat = cyc - acc_cyc + 1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_res"}, {16'd0, result}, {16'd0, e.res});
      check({tag, "_flags"}, {27'd0, z, n, v, c, err}, {27'd0, e.flg});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = '0;
    b         = '0;

    // Reset state
    #12;
    check("rst_res", {16'd0, result}, 32'd0);
    check("rst_flags", {27'd0, z, n, v, c, err}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD overflow and SUB equal operands
    sb.push_back(mk(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    issue(ALU_ADD, 16'h7FFF, 16'h0001);
    collect("add");
    check("add_lat", lat, 32'd1);
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    issue(ALU_SUB, 16'h0005, 16'h0005);
    collect("sub");

    // Shifts and rotates on 0x8001
    sb.push_back(mk(16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(ALU_SRA, 16'h8001, 16'h0011);
    collect("sra");
    sb.push_back(mk(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_SRL, 16'h8001, 16'h0001);
    collect("srl");
    sb.push_back(mk(16'h0018, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_ROL, 16'h8001, 16'h0004);
    collect("rol");
    sb.push_back(mk(16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(ALU_ROR, 16'h8001, 16'h0001);
    collect("ror");
    sb.push_back(mk(16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(ALU_SLL, 16'h8001, 16'h0010);
    collect("sll0");

    // Multiply: latency, in_ready low throughout, wraparound
    sb.push_back(mk(16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_MUL, 16'h0123, 16'h0045);
    collect("mul1");
    check("mul1_lat", lat, 32'd17);
    check("mul1_rdy_low", {31'd0, rdy_seen}, 32'd0);
    sb.push_back(mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_MUL, 16'hFFFF, 16'hFFFF);
    collect("mul2");
    check("mul2_lat", lat, 32'd17);

    // Backpressure: result held, second request refused
    out_ready = 1'b0;
    sb.push_back(mk(16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_NAND, 16'hF0F0, 16'hFF00);
    in_valid = 1'b1;
    op = ALU_ADD;
    a  = 16'h0001;
    b  = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res", {16'd0, result}, 32'h0FFF);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    check("bp_flags", {27'd0, z, n, v, c, err}, {27'd0, e.flg});
    out_ready = 1'b1;
    #1;
    check("bp_no_same_cycle", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("bp_no_accept", {31'd0, out_valid}, 32'd0);

    // Illegal opcode, then a legal op clears err
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(4'd12, 16'h1234, 16'h5678);
    collect("illegal");
    check("illegal_lat", lat, 32'd1);
    sb.push_back(mk(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(ALU_XOR, 16'hAAAA, 16'h5555);
    collect("xor");

    // Asynchronous reset mid-multiply aborts it
    issue(ALU_MUL, 16'h1234, 16'h5678);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_res", {16'd0, result}, 32'd0);
    check("mrst_flags", {27'd0, z, n, v, c, err}, 32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vld_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) vld_seen = 1'b1;
    end
    check("mrst_no_pulse", {31'd0, vld_seen}, 32'd0);
    sb.push_back(mk(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(ALU_ADD, 16'h0002, 16'h0003);
    collect("add_after_rst");

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_seq
